// File: rtl/instr_fetch_buffer_pkg.sv
// instr_fetch_buffer_pkg: shared fetch constants and slot record type
package instr_fetch_buffer_pkg;
  localparam logic [31:0] INITIAL_ADDRESS = 32'h0000_3000;
  localparam int INSTR_WIDTH = 32;
  localparam int FETCH_WORD_BYTES = 4;
  typedef struct packed {
    logic pending;
    logic [31:0] pc;
    logic [INSTR_WIDTH-1:0] instr;
  } slot_t;
endpackage

// File: rtl/ifb_slot_store.sv
// ifb_slot_store: DEPTH slots of {pending, pc, instr} with alloc, fill and head-read ports
module ifb_slot_store
  import instr_fetch_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       alloc_en,
  input  logic [$clog2(DEPTH)-1:0]   alloc_idx,
  input  logic [31:0]                alloc_pc,
  input  logic                       fill_en,
  input  logic [$clog2(DEPTH)-1:0]   fill_idx,
  input  logic [INSTR_WIDTH-1:0]     fill_instr,
  input  logic [$clog2(DEPTH)-1:0]   head_idx,
  output logic [31:0]                head_pc,
  output logic [INSTR_WIDTH-1:0]     head_instr,
  output logic                       head_pending
);
  slot_t slots [DEPTH];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) slots[i] <= '0;
    end else begin
      if (alloc_en) begin
        slots[alloc_idx].pending <= 1'b1;
        slots[alloc_idx].pc <= alloc_pc;
      end
      if (fill_en) begin
        slots[fill_idx].pending <= 1'b0;
        slots[fill_idx].instr <= fill_instr;
      end
    end
  end
  assign head_pc = slots[head_idx].pc;
  assign head_instr = slots[head_idx].instr;
  assign head_pending = slots[head_idx].pending;
endmodule

// File: rtl/instr_fetch_buffer.sv
// instr_fetch_buffer: fetch PC owner, in-order imem requests, slot queue to decode; FETCH_BYPASS_EN adds same-cycle response bypass
module instr_fetch_buffer
  import instr_fetch_buffer_pkg::*;
#(
  parameter int          DEPTH      = 4,
  parameter logic [31:0] RESET_ADDR = INITIAL_ADDRESS
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  output logic                     imem_req_valid,
  output logic [31:0]              imem_req_addr,
  input  logic                     imem_req_ready,
  input  logic                     imem_rsp_valid,
  input  logic [INSTR_WIDTH-1:0]   imem_rsp_data,
  output logic                     out_valid,
  output logic [31:0]              out_pc,
  output logic [INSTR_WIDTH-1:0]   out_instr,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int DW = AW + 4;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [31:0] fetch_pc;
  logic [AW-1:0] head, tail, fill;
  logic [AW:0] npend;
  logic [DW-1:0] drop_cnt, outstanding;
  logic [31:0] head_pc;
  logic [INSTR_WIDTH-1:0] head_instr;
  logic head_pending, req_fire, rsp_drop, rsp_fill, fill_we, deq;
  assign imem_req_valid = !reset && !redirect_valid && count < FULL;
  assign imem_req_addr = fetch_pc;
  assign req_fire = imem_req_valid && imem_req_ready;
  assign rsp_drop = imem_rsp_valid && drop_cnt != '0;
  assign rsp_fill = imem_rsp_valid && drop_cnt == '0 && npend != '0;
  assign outstanding = drop_cnt + DW'(npend);
  assign out_pc = head_pc;
  assign deq = out_valid && out_ready;
`ifdef FETCH_BYPASS_EN
  logic byp;
  // a pending head is always the fill target, so the arriving word belongs to it
  assign byp = rsp_fill && head_pending && count != '0;
  assign out_valid = (count != '0 && !head_pending) || byp;
  assign out_instr = byp ? imem_rsp_data : head_instr;
  assign fill_we = rsp_fill && !(byp && out_ready);
`else
  assign out_valid = count != '0 && !head_pending;
  assign out_instr = head_instr;
  assign fill_we = rsp_fill;
`endif
  ifb_slot_store #(.DEPTH(DEPTH)) u_store (
    .clk(clk),
    .reset(reset),
    .alloc_en(req_fire),
    .alloc_idx(tail),
    .alloc_pc(fetch_pc),
    .fill_en(fill_we && !redirect_valid),
    .fill_idx(fill),
    .fill_instr(imem_rsp_data),
    .head_idx(head),
    .head_pc(head_pc),
    .head_instr(head_instr),
    .head_pending(head_pending)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc <= RESET_ADDR;
      head <= '0;
      tail <= '0;
      fill <= '0;
      count <= '0;
      npend <= '0;
      drop_cnt <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_pc[31:2], 2'b00};
      head <= '0;
      tail <= '0;
      fill <= '0;
      count <= '0;
      npend <= '0;
      // a response landing in the redirect cycle is already one of the discarded ones
      drop_cnt <= outstanding - DW'(imem_rsp_valid && outstanding != '0);
    end else begin
      fetch_pc <= req_fire ? fetch_pc + 32'(FETCH_WORD_BYTES) : fetch_pc;
      tail <= tail + AW'(req_fire);
      fill <= fill + AW'(rsp_fill);
      head <= head + AW'(deq);
      count <= count + (AW+1)'(req_fire) - (AW+1)'(deq);
      npend <= npend + (AW+1)'(req_fire) - (AW+1)'(rsp_fill);
      drop_cnt <= drop_cnt - DW'(rsp_drop);
    end
  end
endmodule
